// File: rtl/instr_loader_pkg.sv
// rtl/instr_loader_pkg.sv - opcode macros, loader state encoding and shared constants
`ifndef INSTR_LOADER_OPCODES
`define INSTR_LOADER_OPCODES
`define NOP 8'h00
`define HLT 8'h3F
`endif

package instr_loader_pkg;

  typedef enum logic [1:0] {
    LEN_HI = 2'd0,
    LEN_LO = 2'd1,
    DATA   = 2'd2,
    RUN    = 2'd3
  } load_state_t;

  localparam logic [7:0]  NOP_OP       = `NOP;
  localparam logic [7:0]  HLT_OP       = `HLT;
  localparam logic [31:0] NOP_WORD_DEF = {NOP_OP, 24'h0};
  localparam logic [31:0] HLT_WORD_DEF = {HLT_OP, 24'h0};

endpackage

// File: rtl/instr_store_ram.sv
// rtl/instr_store_ram.sv - DEPTH x 32 instruction store, synchronous write, asynchronous read
module instr_store_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - byte-stream program loader that holds the core in reset, then serves
// instructions from the core's PC out of the loaded store
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int          DEPTH    = 256,
  parameter int          AW       = 8,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEF,
  parameter logic [31:0] HLT_WORD = HLT_WORD_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  input  logic [7:0]  load_data,
  output logic        load_ready,
  input  logic        reload,
  input  logic [31:0] pc,
  output logic [31:0] instruction,
  output logic        cpu_reset,
  output logic [15:0] loaded_words,
  output logic        load_err
);

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  load_state_t state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] ptr_q, ptr_d;
  logic [15:0] loaded_q, loaded_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] asm_q, asm_d;
  logic        cpu_rst_q, cpu_rst_d;
  logic        err_q, err_d;
  logic        accept, wr_en;
  logic [31:0] wr_data, rd_data;
  logic [15:0] len_full, ptr_inc;

  assign load_ready = (state_q != RUN);
  // reload wins over a simultaneous byte, which is then left unconsumed
  assign accept     = load_valid && load_ready && !reload;
  assign len_full   = {len_q[15:8], load_data};
  assign ptr_inc    = ptr_q + 16'd1;
  assign wr_data    = {asm_q, load_data};

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    ptr_d     = ptr_q;
    loaded_d  = loaded_q;
    cnt_d     = cnt_q;
    asm_d     = asm_q;
    cpu_rst_d = cpu_rst_q;
    err_d     = err_q;
    wr_en     = 1'b0;
    if (reload) begin
      state_d   = LEN_HI;
      cpu_rst_d = 1'b0;
      ptr_d     = '0;
      cnt_d     = '0;
      err_d     = 1'b0;
    end else if (accept) begin
      case (state_q)
        LEN_HI: begin
          len_d   = {load_data, len_q[7:0]};
          state_d = LEN_LO;
        end
        LEN_LO: begin
          len_d = len_full;
          ptr_d = '0;
          cnt_d = '0;
          err_d = err_q | ({1'b0, len_full} > DEPTH_W);
          if (len_full == 16'd0) begin
            state_d   = RUN;
            cpu_rst_d = 1'b1;
            loaded_d  = '0;
          end else begin
            state_d = DATA;
          end
        end
        DATA: begin
          asm_d = wr_data[23:0];
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            // words past the store are dropped but still count toward the length
            wr_en = ({1'b0, ptr_q} < DEPTH_W);
            ptr_d = ptr_inc;
            if (ptr_inc == len_q) begin
              state_d   = RUN;
              cpu_rst_d = 1'b1;
              loaded_d  = ({1'b0, len_q} > DEPTH_W) ? DEPTH_W[15:0] : len_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= LEN_HI;
      len_q     <= '0;
      ptr_q     <= '0;
      loaded_q  <= '0;
      cnt_q     <= '0;
      asm_q     <= '0;
      cpu_rst_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      ptr_q     <= ptr_d;
      loaded_q  <= loaded_d;
      cnt_q     <= cnt_d;
      asm_q     <= asm_d;
      cpu_rst_q <= cpu_rst_d;
      err_q     <= err_d;
    end
  end

  instr_store_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_store (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (ptr_q[AW-1:0]),
    .wr_data (wr_data),
    .rd_addr (pc[AW-1:0]),
    .rd_data (rd_data)
  );

  assign cpu_reset    = cpu_rst_q;
  assign loaded_words = loaded_q;
  assign load_err     = err_q;
  assign instruction  = !cpu_rst_q                  ? NOP_WORD :
                        (pc < {16'h0, loaded_q})    ? rd_data  : HLT_WORD;

endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - directed scoreboard bench for instr_loader
module tb_instr_loader;

  localparam logic [31:0] NOP_W = 32'h0000_0000;
  localparam logic [31:0] HLT_W = 32'h3F00_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_valid = 1'b0;
  logic [7:0]  load_data = 8'h00;
  logic        load_ready;
  logic        reload = 1'b0;
  logic [31:0] pc = 32'h0;
  logic [31:0] instruction;
  logic        cpu_reset;
  logic [15:0] loaded_words;
  logic        load_err;

  int total = 0;
  int bad = 0;
  bit ready_ok;
  bit nop_ok;
  logic [31:0] exp_q[$];

  instr_loader #(.DEPTH(256), .AW(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_ready   (load_ready),
    .reload       (reload),
    .pc           (pc),
    .instruction  (instruction),
    .cpu_reset    (cpu_reset),
    .loaded_words (loaded_words),
    .load_err     (load_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    load_valid = 1'b1;
    load_data  = b;
    @(negedge clk);
    if (!load_ready) ready_ok = 1'b0;
    if (!cpu_reset && instruction !== NOP_W) nop_ok = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic send_hdr(input logic [15:0] n);
    send_byte(n[15:8]);
    send_byte(n[7:0]);
  endtask

  task automatic send_word(input logic [31:0] w, input bit push);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
    if (push) exp_q.push_back(w);
  endtask

  task automatic do_reload();
    load_valid = 1'b0;
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
    exp_q.delete();
  endtask

  task automatic drain(input string tag);
    int i;
    i = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      pc = i;
      #1;
      check(tag, instruction, exp_q.pop_front());
      i++;
    end
  endtask

  initial begin
    // reset state, applied asynchronously from time 0
    #1;
    check("rst_cpu_reset", 32'(cpu_reset), 32'd0);
    check("rst_loaded", 32'(loaded_words), 32'd0);
    check("rst_err", 32'(load_err), 32'd0);
    check("rst_ready", 32'(load_ready), 32'd1);
    check("rst_instr", instruction, NOP_W);
    #16 reset = 1'b1;
    @(posedge clk);
    #1;

    // two-word load with valid held high
    ready_ok = 1'b1;
    nop_ok = 1'b1;
    pc = 0;
    send_hdr(16'd2);
    send_word(32'hAABBCCDD, 1'b1);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    check("pre_last_cpu_reset", 32'(cpu_reset), 32'd0);
    send_byte(8'h44);
    exp_q.push_back(32'h11223344);
    load_valid = 1'b0;
    check("t1_cpu_reset", 32'(cpu_reset), 32'd1);
    check("t1_loaded", 32'(loaded_words), 32'd2);
    check("t1_ready_low", 32'(load_ready), 32'd0);
    check("t1_nop_during_load", 32'(nop_ok), 32'd1);
    check("t1_ready_during_load", 32'(ready_ok), 32'd1);
    drain("t1_readback");
    pc = 2; #1;
    check("t1_hlt_pc2", instruction, HLT_W);
    pc = 32'h0001_0000; #1;
    check("t1_hlt_upper", instruction, HLT_W);

    // zero-length load
    do_reload();
    check("t2_reload_cpu_reset", 32'(cpu_reset), 32'd0);
    check("t2_reload_ready", 32'(load_ready), 32'd1);
    pc = 0;
    send_byte(8'h00);
    check("t2_after_hi", 32'(cpu_reset), 32'd0);
    send_byte(8'h00);
    load_valid = 1'b0;
    check("t2_cpu_reset", 32'(cpu_reset), 32'd1);
    check("t2_loaded", 32'(loaded_words), 32'd0);
    check("t2_hlt_pc0", instruction, HLT_W);

    // oversized header: DEPTH+1 words
    do_reload();
    ready_ok = 1'b1;
    nop_ok = 1'b1;
    send_hdr(16'd257);
    check("t3_err_set", 32'(load_err), 32'd1);
    for (int i = 0; i < 257; i++) send_word(32'hC0DE_0000 | 32'(i), i < 256);
    load_valid = 1'b0;
    check("t3_ready_all", 32'(ready_ok), 32'd1);
    check("t3_nop_during_load", 32'(nop_ok), 32'd1);
    check("t3_cpu_reset", 32'(cpu_reset), 32'd1);
    check("t3_loaded", 32'(loaded_words), 32'd256);
    check("t3_err_sticky", 32'(load_err), 32'd1);
    drain("t3_readback");
    pc = 256; #1;
    check("t3_hlt_256", instruction, HLT_W);

    // reload mid-load, colliding with a valid byte
    do_reload();
    check("t4_err_cleared", 32'(load_err), 32'd0);
    send_hdr(16'd2);
    send_word(32'h1122_3344, 1'b1);
    send_byte(8'h55);
    send_byte(8'h66);
    load_valid = 1'b1;
    load_data = 8'h77;
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
    load_valid = 1'b0;
    exp_q.delete();
    check("t4_cpu_reset", 32'(cpu_reset), 32'd0);
    check("t4_ready", 32'(load_ready), 32'd1);
    send_hdr(16'd1);
    send_word(32'hDEADBEEF, 1'b1);
    load_valid = 1'b0;
    check("t4_loaded", 32'(loaded_words), 32'd1);
    check("t4_cpu_reset_run", 32'(cpu_reset), 32'd1);
    drain("t4_readback");
    pc = 1; #1;
    check("t4_hlt_pc1", instruction, HLT_W);

    // asynchronous reset in the middle of DATA
    do_reload();
    send_hdr(16'd3);
    send_word(32'h0102_0304, 1'b0);
    send_byte(8'h05);
    send_byte(8'h06);
    load_valid = 1'b0;
    pc = 0;
    #3 reset = 1'b0;
    #1;
    check("t5_cpu_reset", 32'(cpu_reset), 32'd0);
    check("t5_ready", 32'(load_ready), 32'd1);
    check("t5_loaded", 32'(loaded_words), 32'd0);
    check("t5_nop", instruction, NOP_W);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("t5_still_held", 32'(cpu_reset), 32'd0);
    check("t5_nop_after", instruction, NOP_W);
    nop_ok = 1'b1;
    send_hdr(16'd1);
    send_word(32'hABCDEF01, 1'b1);
    load_valid = 1'b0;
    check("t5_nop_until_done", 32'(nop_ok), 32'd1);
    check("t5_loaded_new", 32'(loaded_words), 32'd1);
    drain("t5_readback");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
